// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine.
//   state_t : controller state encoding (IDLE, CALC, DONE)
//   NIB_W   : width of one arithmetic slice in bits
package serial_addsub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_nibble_addsub.sv
// nibble_addsub: combinational 4-bit ripple adder slice.
//   a, b  : slice operands
//   inv   : invert b before adding (subtract when paired with cin = 1)
//   cin   : carry into bit 0, independent of inv so slices can be chained
//   s     : slice sum
//   cout  : carry out of bit 3
//   c3    : carry into bit 3, used for signed-overflow detection
module nibble_addsub
    import serial_addsub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             inv,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout,
    output logic             c3
);

    logic [NIB_W:0]   carry;
    logic [NIB_W-1:0] b_eff;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
        assign b_eff[gi]    = b[gi] ^ inv;
        assign s[gi]        = a[gi] ^ b_eff[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
    end

    assign cout = carry[NIB_W];
    assign c3   = carry[NIB_W-1];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle two's-complement add/subtract, one 4-bit slice
// per clock, LSB first, through a single reused nibble_addsub slice.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, sub sampled on accept)
//   a, b                 : WIDTH-bit operands
//   sub                  : 0 = A+B, 1 = A-B
//   out_valid / out_ready: result handshake
//   result               : WIDTH-bit sum or difference
//   cout                 : carry out of MSB (subtract: 1 = no borrow)
//   ov                   : signed overflow
//   zero                 : result == 0
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ov,
    output logic             zero
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NIB);

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              sub_reg;
    logic              carry_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              cout_reg;
    logic              ov_reg;
    logic              zero_reg;
    logic              out_valid_reg;

    logic [NIB_W-1:0]  a_nib [NIB];
    logic [NIB_W-1:0]  b_nib [NIB];
    logic [NIB_W-1:0]  slice_a;
    logic [NIB_W-1:0]  slice_b;
    logic [NIB_W-1:0]  slice_s;
    logic              slice_cout;
    logic              slice_c3;
    logic [WIDTH-1:0]  result_next;

    // Split latched operands into slices; the mux then picks slice idx.
    // result_next is the result register with only slice idx replaced,
    // so the zero flag can be taken from the complete final value.
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign a_nib[gi] = a_reg[gi*NIB_W +: NIB_W];
        assign b_nib[gi] = b_reg[gi*NIB_W +: NIB_W];
        assign result_next[gi*NIB_W +: NIB_W] =
            (idx_reg == IDX_W'(gi)) ? slice_s : result_reg[gi*NIB_W +: NIB_W];
    end

    assign slice_a = a_nib[idx_reg];
    assign slice_b = b_nib[idx_reg];

    nibble_addsub u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .inv  (sub_reg),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            result_reg    <= '0;
            cout_reg      <= 1'b0;
            ov_reg        <= 1'b0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        sub_reg   <= sub;
                        // Subtract is A + ~B + 1: the +1 enters as the first carry.
                        carry_reg <= sub;
                        idx_reg   <= '0;
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    result_reg <= result_next;
                    carry_reg  <= slice_cout;
                    if (idx_reg == IDX_W'(NIB - 1)) begin
                        cout_reg  <= slice_cout;
                        ov_reg    <= slice_cout ^ slice_c3;
                        zero_reg  <= (result_next == '0);
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // out_valid rises on the first DONE cycle, giving a fixed
                    // NIB+1 edge latency from acceptance; out_ready only
                    // matters once out_valid is visible.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign cout      = cout_reg;
    assign ov        = ov_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: directed cases plus randomized traffic with
// random output backpressure, checked through an expectation queue.
module tb_serial_addsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         cout;
    logic         ov;
    logic         zero;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   bp_on = 1'b0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ov        (ov),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int   ux, uy, sx, sy, usum, ssum;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= (1 << (W-1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W-1))) ? uy - (1 << W) : uy;
        if (!s) begin
            usum = ux + uy;
            ssum = sx + sy;
            e.c  = (usum >= (1 << W));
        end else begin
            usum = ux - uy;
            ssum = sx - sy;
            e.c  = (ux >= uy);
        end
        e.r = W'(usum);
        e.v = (ssum > (1 << (W-1)) - 1) || (ssum < -(1 << (W-1)));
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: pops on every output handshake and also checks that a
    // stalled output stays valid and stable.
    bit           stall_prev = 1'b0;
    logic [W-1:0] res_prev = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", 32'(result), 32'(res_prev));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %0h, required no output", result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e.r));
                    check("cout", 32'(cout), 32'(e.c));
                    check("ov", 32'(ov), 32'(e.v));
                    check("zero", 32'(zero), 32'(e.z));
                    $display("txn result=%04h cout=%0b ov=%0b zero=%0b", result, cout, ov, zero);
                end
            end
            stall_prev = out_valid && !out_ready;
            res_prev   = result;
        end
    end

    always @(posedge clk) begin
        if (bp_on) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Issue one request; returns 1 ns after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        a = x; b = y; sub = s; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model(x, y, s));
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy for 200 cycles, required idle");
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'hFFFF;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int cnt;
        bit seen;
        exp_t dropped;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {29'd0, cout, ov, zero}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Add with latency measurement
        send(16'h1234, 16'h0FCD, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", 32'(cnt), 32'd5);
        wait_idle();

        send(16'h0005, 16'h0007, 1'b1);
        wait_idle();
        send(16'h7FFF, 16'h0001, 1'b0);
        wait_idle();
        send(16'h8000, 16'h0001, 1'b1);
        wait_idle();

        // Backpressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(16'h00FF, 16'h0001, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(result), 32'h0100);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Operand change during CALC
        send(16'hA5A5, 16'h1234, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            in_valid = 1'($urandom);
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset mid-CALC with idx == 2
        send(16'h4321, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        dropped = exp_q.pop_back();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flags", {29'd0, cout, ov, zero}, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", 32'(seen), 32'd0);

        send(16'hFFFF, 16'h0001, 1'b0);
        wait_idle();

        // Random traffic with random backpressure
        bp_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(pick(), pick(), 1'($urandom));
        end
        bp_on = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
